pipeline_stall_controller: RTL and testbench

//  Consumes hazard_detected from the hazard detection unit, branch_taken from EXE and SRAM handshake

---
 rtl/pipeline_stall_controller_pkg.sv | 18 +
 rtl/pipeline_stall_controller_sat.sv | 24 ++
 rtl/pipeline_stall_controller.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_t      : controller FSM encoding (RUN / MEM_WAIT)
//   CNT_W_DEF    : default width of the statistics counters
//   cnt_width()  : bits needed to hold 0..max
package pipeline_stall_controller_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 16;

    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   clr  in  synchronous clear, wins over inc
//   inc  in  count enable
//   cnt  out current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/flush controller. Decodes memory-wait, taken-branch and
// hazard conditions into per-register freeze/flush controls with 0-cycle
// latency, tracks memory-wait and hazard-stall durations for watchdog flags
// and keeps saturating stall/flush statistics.
//   clk, rst                       clock, synchronous active-high reset
//   hazard_detected, branch_taken  ID hazard, EXE taken branch
//   mem_req, sram_ready            MEM-stage access and its completion
//   clr_stats                      clear stall_cycles / flush_count
//   *_freeze, *_flush, mem_wb_bubble  pipeline register controls
//   mem_wait                       registered: FSM in MEM_WAIT
//   mem_timeout, hazard_deadlock   sticky watchdog errors (cleared by rst)
//   stall_cycles, flush_count      saturating statistics
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = 255,
    parameter int MAX_HAZARD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             clr_stats,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_freeze,
    output logic             id_exe_flush,
    output logic             exe_mem_freeze,
    output logic             mem_wb_bubble,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic             hazard_deadlock,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WT_W = cnt_width(MEM_TIMEOUT);
    localparam int HZ_W = cnt_width(MAX_HAZARD);

    state_t          state, state_next;
    logic            mem_busy, hazard_act;
    logic [WT_W-1:0] wait_cnt;
    logic [HZ_W-1:0] haz_cnt;

    assign mem_busy = mem_req & ~sram_ready;
    // Hazard only stalls when neither a memory wait nor a taken branch outranks it.
    assign hazard_act = ~rst & ~mem_busy & ~branch_taken & hazard_detected;
    assign mem_wait = (state == ST_MEM_WAIT);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        pc_freeze      = 1'b0;
        if_id_freeze   = 1'b0;
        if_id_flush    = 1'b0;
        id_exe_freeze  = 1'b0;
        id_exe_flush   = 1'b0;
        exe_mem_freeze = 1'b0;
        mem_wb_bubble  = 1'b0;

        case (state)
            ST_RUN:      if (mem_busy)  state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!mem_busy) state_next = ST_RUN;
            default:     state_next = ST_RUN;
        endcase

        // Release cycle out of MEM_WAIT decodes exactly like RUN, so the
        // controls depend only on the current inputs.
        if (!rst) begin
            if (mem_busy) begin
                // Branch/hazard stay latched in the frozen registers and are
                // re-evaluated once memory releases.
                pc_freeze      = 1'b1;
                if_id_freeze   = 1'b1;
                id_exe_freeze  = 1'b1;
                exe_mem_freeze = 1'b1;
                mem_wb_bubble  = 1'b1;
            end else if (branch_taken) begin
                // Hazarding instruction is flushed anyway, so no stall.
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (hazard_detected) begin
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
                id_exe_flush = 1'b1;
            end
        end
    end

    // Flags are set on the edge where the counter reaches its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout     <= 1'b0;
            hazard_deadlock <= 1'b0;
        end else begin
            if (state == ST_MEM_WAIT && wait_cnt >= WT_W'(MEM_TIMEOUT - 1))
                mem_timeout <= 1'b1;
            if (hazard_act && haz_cnt >= HZ_W'(MAX_HAZARD - 1))
                hazard_deadlock <= 1'b1;
        end
    end

    sat_counter #(.W(WT_W)) u_wait_cnt (
        .clk(clk), .rst(rst),
        .clr(state == ST_RUN), .inc(state == ST_MEM_WAIT),
        .cnt(wait_cnt)
    );

    // A memory wait neither advances nor clears the hazard run length.
    sat_counter #(.W(HZ_W)) u_haz_cnt (
        .clk(clk), .rst(rst),
        .clr(~hazard_act & ~mem_busy), .inc(hazard_act),
        .cnt(haz_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk(clk), .rst(rst),
        .clr(clr_stats), .inc(pc_freeze),
        .cnt(stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_count (
        .clk(clk), .rst(rst),
        .clr(clr_stats), .inc(if_id_flush),
        .cnt(flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    localparam int CNT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hazard_detected, branch_taken, mem_req, sram_ready, clr_stats;
    logic pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush;
    logic exe_mem_freeze, mem_wb_bubble, mem_wait, mem_timeout, hazard_deadlock;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [6:0] ctrl;

    int checks = 0;
    int failures = 0;

    pipeline_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .MAX_HAZARD(4)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .clr_stats(clr_stats),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_exe_freeze(id_exe_freeze), .id_exe_flush(id_exe_flush),
        .exe_mem_freeze(exe_mem_freeze), .mem_wb_bubble(mem_wb_bubble),
        .mem_wait(mem_wait), .mem_timeout(mem_timeout), .hazard_deadlock(hazard_deadlock),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // {pc, if_id_frz, if_id_fl, id_exe_frz, id_exe_fl, exe_mem_frz, bubble}
    assign ctrl = {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze,
                   id_exe_flush, exe_mem_freeze, mem_wb_bubble};

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HAZ  = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MEM  = 7'b1101011;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hazard_detected = 1'b1; branch_taken = 1'b0;
        mem_req = 1'b0; sram_ready = 1'b0; clr_stats = 1'b0;

        // Reset: controls forced low even with a hazard present
        #1 chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        tick; tick;
        chk("rst_mem_wait", 32'(mem_wait), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        chk("rst_deadlock", 32'(hazard_deadlock), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_flush", 32'(flush_count), 0);

        // Single-cycle hazard
        rst = 1'b0;
        #1 chk("haz_ctrl", 32'(ctrl), 32'(C_HAZ));
        tick; hazard_detected = 1'b0;
        #1 chk("haz_release", 32'(ctrl), 32'(C_NONE));
        chk("haz_stall", 32'(stall_cycles), 1);

        // Branch beats hazard
        branch_taken = 1'b1; hazard_detected = 1'b1;
        #1 chk("br_ctrl", 32'(ctrl), 32'(C_BR));
        tick; branch_taken = 1'b0; hazard_detected = 1'b0;
        #1 chk("br_flush", 32'(flush_count), 1);
        chk("br_stall", 32'(stall_cycles), 1);

        // 3-cycle memory wait; branch+hazard during cycle 2 are outranked
        mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            hazard_detected = (i == 2); branch_taken = (i == 2);
            #1 chk($sformatf("mem_ctrl_%0d", i), 32'(ctrl), 32'(C_MEM));
            chk($sformatf("mem_wait_%0d", i), 32'(mem_wait), (i >= 2) ? 1 : 0);
            tick;
        end
        sram_ready = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
        #1 chk("mem_rel_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("mem_rel_wait", 32'(mem_wait), 1);
        tick; mem_req = 1'b0; sram_ready = 1'b0;
        #1 chk("mem_after_wait", 32'(mem_wait), 0);
        chk("mem_stall", 32'(stall_cycles), 4);
        chk("mem_no_timeout", 32'(mem_timeout), 0);

        rst = 1'b1; tick; rst = 1'b0;

        // Timeout after 4th MEM_WAIT cycle, sticky after release
        mem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1 chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), (i >= 6) ? 1 : 0);
            tick;
        end
        sram_ready = 1'b1;
        #1 chk("to_rel_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("to_rel_flag", 32'(mem_timeout), 1);
        tick; mem_req = 1'b0; sram_ready = 1'b0;
        #1 chk("to_sticky", 32'(mem_timeout), 1);
        chk("to_wait_off", 32'(mem_wait), 0);

        // Reset while in MEM_WAIT
        mem_req = 1'b1; tick;
        #1 chk("rmw_wait", 32'(mem_wait), 1);
        chk("rmw_stall_pre", 32'(stall_cycles), 7);
        rst = 1'b1;
        #1 chk("rmw_ctrl_rst", 32'(ctrl), 32'(C_NONE));
        tick; rst = 1'b0; mem_req = 1'b0;
        #1 chk("rmw_wait_off", 32'(mem_wait), 0);
        chk("rmw_timeout", 32'(mem_timeout), 0);
        chk("rmw_stall", 32'(stall_cycles), 0);
        chk("rmw_ctrl", 32'(ctrl), 32'(C_NONE));

        // Long hazard: deadlock after 4 cycles, stall saturates at 7
        hazard_detected = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1 chk($sformatf("hz_dl_%0d", i), 32'(hazard_deadlock), (i >= 5) ? 1 : 0);
            chk($sformatf("hz_stall_%0d", i), 32'(stall_cycles), (i - 1 > 7) ? 7 : i - 1);
            tick;
        end
        #1 chk("hz_sat", 32'(stall_cycles), 7);
        clr_stats = 1'b1;
        tick; clr_stats = 1'b0; hazard_detected = 1'b0;
        #1 chk("clr_stall", 32'(stall_cycles), 0);
        chk("clr_dl_sticky", 32'(hazard_deadlock), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
